// File: rtl/instruction_fetch_if.sv
// Bus between the instruction fetch unit and its host/core: program loading,
// start/done handshake and the issued instruction.
interface instruction_fetch_if #(
  parameter int AW = 4,
  parameter int IW = 16
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          start;
  logic          done;
  logic [IW-1:0] iin;
  logic [AW-1:0] pc;
  logic          valid;
  logic          halted;

  // master: host/core side; slave: the fetch unit
  modport master (
    output load_en, load_addr, load_data, start, done,
    input  iin, pc, valid, halted
  );

  modport slave (
    input  load_en, load_addr, load_data, start, done,
    output iin, pc, valid, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: loadable program memory plus PC, issuing one word at a
// time to the core and advancing on the core's done pulse.
//
// state | meaning
// IDLE  | after reset; program may be loaded, waits for start
// FETCH | one-cycle read of mem[pc]; issues the word or halts on the halt word
// ISSUE | iin/pc held with valid=1 until done
// HALT  | program finished; program may be reloaded and restarted
module instruction_fetch #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  instruction_fetch_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [IW-1:0] HALT_WORD = {IW{1'b1}};

  logic [1:0]    state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] pc_q;
  logic [IW-1:0] iin_q;
  logic          valid_q;
  logic          halted_q;
  logic          load_ok;
  logic [IW-1:0] rd_word;

  assign load_ok = (state == IDLE) || (state == HALT);
  assign rd_word = mem[pc_q];

  // Memory is deliberately left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if (!resetn && load_ok && bus.load_en)
      mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= IDLE;
      pc_q     <= '0;
      iin_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          // a write in the same cycle wins over start
          if (bus.start && !bus.load_en) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (rd_word == HALT_WORD) begin
            iin_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
            state    <= HALT;
          end else begin
            iin_q   <= rd_word;
            valid_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.done) begin
            valid_q <= 1'b0;
            if (pc_q == LAST_ADDR) begin
              iin_q    <= '0;
              halted_q <= 1'b1;
              state    <= HALT;
            end else begin
              pc_q  <= pc_q + AW'(1);
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iin    = iin_q;
  assign bus.pc     = pc_q;
  assign bus.valid  = valid_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// programs checked against a simple program-walk model.
module tb_instruction_fetch;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  logic [15:0] model_mem [16];

  instruction_fetch_if #(.AW(4), .IW(16)) bus ();

  instruction_fetch #(.DEPTH(16), .AW(4), .IW(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_word(input logic [3:0] addr, input logic [15:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    tick();
    bus.load_en   = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i <= budget; i++) begin
      if (bus.valid || bus.halted) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    load_word(4'd0, 16'h2468);
    for (int a = 1; a < 16; a++) load_word(4'(a), 16'($urandom_range(0, 16'hFFFE)));
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      bus.done  = 1'($urandom_range(0, 1));
      bus.start = 1'($urandom_range(0, 1));
      tick();
    end
    bus.done  = 1'b0;
    bus.start = 1'b0;
    do_reset();
    checks++;
    if (bus.pc !== 4'd0 || bus.iin !== 16'h0 || bus.valid !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: pc=%0d iin=%h valid=%b halted=%b, want 0/0000/0/0",
               bus.pc, bus.iin, bus.valid, bus.halted);
    end
    pulse_start();
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.iin !== 16'h2468 || bus.pc !== 4'd0) begin
      errors++;
      $display("FAIL reset_mem_kept: valid=%b iin=%h pc=%0d, want 1/2468/0", bus.valid, bus.iin, bus.pc);
    end
  endtask

  task automatic test_basic();
    do_reset();
    load_word(4'd0, 16'h1234);
    load_word(4'd1, 16'hABCD);
    load_word(4'd2, 16'hFFFF);
    pulse_start();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: valid=%b one cycle after start, want 0", bus.valid);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.valid !== 1'b1 || bus.iin !== 16'h1234 || bus.pc !== 4'd0) begin
        errors++;
        $display("FAIL basic_hold[%0d]: valid=%b iin=%h pc=%0d, want 1/1234/0", i, bus.valid, bus.iin, bus.pc);
      end
      if (i < 5) tick();
    end
    pulse_done();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_gap: valid=%b after done, want 0", bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.iin !== 16'hABCD || bus.pc !== 4'd1) begin
      errors++;
      $display("FAIL basic_second: valid=%b iin=%h pc=%0d, want 1/abcd/1", bus.valid, bus.iin, bus.pc);
    end
    pulse_done();
    tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.valid !== 1'b0 || bus.pc !== 4'd2 || bus.iin !== 16'h0) begin
      errors++;
      $display("FAIL basic_halt: halted=%b valid=%b pc=%0d iin=%h, want 1/0/2/0000",
               bus.halted, bus.valid, bus.pc, bus.iin);
    end
  endtask

  task automatic test_full_memory();
    bit to;
    for (int a = 0; a < 16; a++) load_word(4'(a), 16'(a + 1));
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      wait_ready(10, to);
      checks++;
      if (to || bus.valid !== 1'b1 || bus.pc !== 4'(k) || bus.iin !== 16'(k + 1)) begin
        errors++;
        $display("FAIL full_issue[%0d]: timeout=%b valid=%b pc=%0d iin=%h, want 1/%0d/%h",
                 k, to, bus.valid, bus.pc, bus.iin, k, 16'(k + 1));
      end
      tick(3);
      pulse_done();
    end
    checks++;
    if (bus.halted !== 1'b1 || bus.valid !== 1'b0 || bus.pc !== 4'd15) begin
      errors++;
      $display("FAIL full_end: halted=%b valid=%b pc=%0d, want 1/0/15", bus.halted, bus.valid, bus.pc);
    end
    tick(4);
    checks++;
    if (bus.halted !== 1'b1 || bus.valid !== 1'b0 || bus.pc !== 4'd15) begin
      errors++;
      $display("FAIL full_no_wrap: halted=%b valid=%b pc=%0d, want 1/0/15", bus.halted, bus.valid, bus.pc);
    end
  endtask

  task automatic test_ignored();
    bit to;
    load_word(4'd0, 16'h1111);
    load_word(4'd1, 16'h2222);
    load_word(4'd2, 16'h3333);
    load_word(4'd3, 16'hFFFF);
    pulse_start();
    tick();
    bus.load_en   = 1'b1;
    bus.load_addr = 4'd0;
    bus.load_data = 16'h5555;
    tick();
    bus.load_en = 1'b0;
    pulse_start();
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.pc !== 4'd0 || bus.iin !== 16'h1111) begin
      errors++;
      $display("FAIL ign_issue_hold: valid=%b pc=%0d iin=%h, want 1/0/1111", bus.valid, bus.pc, bus.iin);
    end
    bus.done = 1'b1;
    tick(2);
    bus.done = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.pc !== 4'd1 || bus.iin !== 16'h2222) begin
      errors++;
      $display("FAIL ign_done_in_fetch: valid=%b pc=%0d iin=%h, want 1/1/2222", bus.valid, bus.pc, bus.iin);
    end
    tick(2);
    checks++;
    if (bus.valid !== 1'b1 || bus.pc !== 4'd1) begin
      errors++;
      $display("FAIL ign_no_advance: valid=%b pc=%0d, want 1/1", bus.valid, bus.pc);
    end
    pulse_done();
    wait_ready(10, to);
    pulse_done();
    wait_ready(10, to);
    checks++;
    if (to || bus.halted !== 1'b1 || bus.pc !== 4'd3) begin
      errors++;
      $display("FAIL ign_halt: timeout=%b halted=%b pc=%0d, want 0/1/3", to, bus.halted, bus.pc);
    end
    pulse_start();
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.iin !== 16'h1111) begin
      errors++;
      $display("FAIL ign_mem_unchanged: valid=%b iin=%h, want 1/1111", bus.valid, bus.iin);
    end
    do_reset();
    bus.start     = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 4'd0;
    bus.load_data = 16'hBEEF;
    tick();
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    model_mem[0] = 16'hBEEF;
    tick(2);
    checks++;
    if (bus.valid !== 1'b0 || bus.halted !== 1'b0 || bus.pc !== 4'd0) begin
      errors++;
      $display("FAIL ign_start_load_idle: valid=%b halted=%b pc=%0d, want 0/0/0", bus.valid, bus.halted, bus.pc);
    end
    pulse_start();
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.iin !== 16'hBEEF) begin
      errors++;
      $display("FAIL ign_write_landed: valid=%b iin=%h, want 1/beef", bus.valid, bus.iin);
    end
  endtask

  task automatic test_restart();
    do_reset();
    load_word(4'd0, 16'hFFFF);
    pulse_start();
    tick();
    checks++;
    if (bus.halted !== 1'b1 || bus.pc !== 4'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL restart_halt0: halted=%b pc=%0d valid=%b, want 1/0/0", bus.halted, bus.pc, bus.valid);
    end
    load_word(4'd0, 16'h7777);
    pulse_start();
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: halted=%b, want 0", bus.halted);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.iin !== 16'h7777 || bus.pc !== 4'd0) begin
      errors++;
      $display("FAIL restart_issue: valid=%b iin=%h pc=%0d, want 1/7777/0", bus.valid, bus.iin, bus.pc);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    do_reset();
    for (int a = 0; a < 6; a++) load_word(4'(a), 16'h0A00 + 16'(a));
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_ready(10, to);
      pulse_done();
    end
    wait_ready(10, to);
    checks++;
    if (to || bus.valid !== 1'b1 || bus.pc !== 4'd3 || bus.iin !== 16'h0A03) begin
      errors++;
      $display("FAIL mid_reach_pc3: timeout=%b valid=%b pc=%0d iin=%h, want 0/1/3/0a03",
               to, bus.valid, bus.pc, bus.iin);
    end
    do_reset();
    checks++;
    if (bus.valid !== 1'b0 || bus.pc !== 4'd0 || bus.iin !== 16'h0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b pc=%0d iin=%h halted=%b, want 0/0/0000/0",
               bus.valid, bus.pc, bus.iin, bus.halted);
    end
    pulse_done();
    tick(3);
    checks++;
    if (bus.valid !== 1'b0 || bus.pc !== 4'd0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_done_ignored: valid=%b pc=%0d halted=%b, want 0/0/0", bus.valid, bus.pc, bus.halted);
    end
  endtask

  task automatic test_random_programs();
    logic [15:0] exp_words [$];
    int          final_pc;
    int          idx;
    bit          to;
    for (int it = 0; it < 12; it++) begin
      do_reset();
      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 5) == 0) load_word(4'(a), 16'hFFFF);
        else load_word(4'(a), 16'($urandom_range(0, 16'hFFFE)));
      end
      exp_words.delete();
      final_pc = 15;
      for (int a = 0; a < 16; a++) begin
        if (model_mem[a] == 16'hFFFF) begin
          final_pc = a;
          break;
        end
        exp_words.push_back(model_mem[a]);
      end
      pulse_start();
      idx = 0;
      for (int guard = 0; guard < 20; guard++) begin
        wait_ready(10, to);
        if (to) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout: iter=%0d idx=%0d", it, idx);
          break;
        end
        if (bus.halted) break;
        checks++;
        if (idx >= exp_words.size() || bus.pc !== 4'(idx) || bus.iin !== exp_words[idx]) begin
          errors++;
          $display("FAIL rand_issue: iter=%0d idx=%0d pc=%0d iin=%h, want pc=%0d iin=%h (expected count %0d)",
                   it, idx, bus.pc, bus.iin, idx,
                   (idx < exp_words.size()) ? exp_words[idx] : 16'h0, exp_words.size());
        end
        tick($urandom_range(0, 3));
        pulse_done();
        idx++;
      end
      checks++;
      if (idx != exp_words.size() || bus.halted !== 1'b1 || bus.pc !== 4'(final_pc) || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_end: iter=%0d issued=%0d halted=%b pc=%0d valid=%b, want %0d/1/%0d/0",
                 it, idx, bus.halted, bus.pc, bus.valid, exp_words.size(), final_pc);
      end
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    resetn        = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.done      = 1'b0;
    tick(2);
    resetn = 1'b0;
    test_reset();
    test_basic();
    test_full_memory();
    test_ignored();
    test_restart();
    test_reset_mid();
    test_random_programs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream instruction source for the processor core.
- Holds a small loadable program memory and a program counter, and presents one 16-bit instruction word at a time on iin.
- Holds iin stable until the core signals completion via done, then fetches the next word.
- Program ends on a halt word (16'hFFFF) or after the last memory address.

Parameters:
DEPTH, 16, number of instruction words in program memory.
AW, 4, address/PC width; DEPTH equals 2**AW.
IW, 16, instruction word width; must match the core's iin width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
resetn  input  1  synchronous, active-high reset: sampled on the rising edge of clk, and a 1 resets the block.
load_en  input  1  program-memory write strobe; honoured only in IDLE or HALT.
load_addr  input  AW  write address.
load_data  input  IW  write data.
start  input  1  begin execution from address 0; honoured only in IDLE or HALT.
done  input  1  one-cycle pulse from the core's control unit (its step-counter clear) marking instruction completion.
iin  output  IW  current instruction word to the core.
pc  output  AW  address of the word on iin.
valid  output  1  iin holds a live instruction.
halted  output  1  program finished.

Behaviour:
- Reset (resetn=1 at edge):
  - state=IDLE, pc=0, iin=0, valid=0, halted=0.
  - Memory contents are not cleared.
  - Reset overrides every other input, including mid-ISSUE; the core sees valid fall on the next cycle.
- FSM states: IDLE, FETCH, ISSUE, HALT. All outputs are registered.
- IDLE:
  - load_en=1 writes mem[load_addr]<=load_data.
  - start=1 with load_en=0: pc<=0, go to FETCH.
  - start and load_en both high: the write is performed and start is ignored.
- FETCH (exactly one cycle, synchronous read of mem[pc]):
  - Word != 16'hFFFF: iin<=word, valid<=1, go to ISSUE.
  - Word == 16'hFFFF: iin<=0, valid<=0, halted<=1, go to HALT; pc keeps the halt address.
- ISSUE:
  - iin and pc are held constant and valid=1 until done=1.
  - On done: valid<=0.
    - If pc==DEPTH-1: halted<=1, go to HALT. The PC does not wrap.
    - Otherwise: pc<=pc+1, go to FETCH.
- HALT:
  - halted=1, valid=0, iin=0.
  - load_en writes as in IDLE.
  - start=1 with load_en=0: halted<=0, pc<=0, go to FETCH.
- Latency:
  - start sampled to valid=1: 2 cycles.
  - done sampled to next valid=1: 2 cycles (1 cycle low, FETCH, then ISSUE).
- Ignored inputs:
  - done outside ISSUE is ignored.
  - start in FETCH or ISSUE is ignored.
  - load_en in FETCH or ISSUE is ignored (no write).
- done and start together in ISSUE: done is processed, start is ignored.
- Arithmetic: pc increments modulo-free. The terminal check at DEPTH-1 guarantees no overflow.
- Memory read and write ports are never active in the same cycle, because writes occur only in IDLE/HALT.

Test Plan:
- Reset: assert resetn 1 cycle after random activity -> pc=0, iin=0, valid=0, halted=0 next cycle; a previously loaded mem[0] is still readable after start.
- Basic sequencing: load mem[0]=16'h1234, mem[1]=16'hABCD, mem[2]=16'hFFFF; pulse start -> 2 cycles later iin=16'h1234, pc=0, valid=1, held for 5 cycles without done.
  - done pulse -> valid=0 for 1 cycle, then iin=16'hABCD, pc=1.
  - Next done -> halted=1, valid=0, pc=2.
- Full-memory run: fill all 16 words with 16'h0001..16'h0010 and answer each valid with done 3 cycles later -> 16 instructions issued in order; after the done at pc=15: halted=1, pc stays 15, no wrap.
- Ignored inputs: during ISSUE, pulse load_en (addr 0, data 16'h5555) and start, and pulse done while in FETCH.
  - Required: memory is unchanged, pc is not reset, and no spurious advance occurs.
  - Same-cycle start+load_en in IDLE: the write lands and the FSM stays in IDLE.
- Restart from HALT: after a halt, load mem[0]=16'h7777 and pulse start -> halted=0, and 2 cycles later iin=16'h7777, pc=0, valid=1.
- Reset mid-operation: assert resetn while in ISSUE at pc=3 -> next cycle valid=0, pc=0, state IDLE; a later done pulse is ignored.
